// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit.
// Holds the memory-operation encoding, its width, the LSU FSM state type
// and small helpers that classify an operation and give its access size.
package lsu_pkg;

  localparam int MEMOP_WIDTH = 4;

  typedef enum logic [MEMOP_WIDTH-1:0] {
    MEM_NONE = 4'd0,
    MEM_LB   = 4'd1,
    MEM_LH   = 4'd2,
    MEM_LW   = 4'd3,
    MEM_LD   = 4'd4,
    MEM_LBU  = 4'd5,
    MEM_LHU  = 4'd6,
    MEM_LWU  = 4'd7,
    MEM_SB   = 4'd8,
    MEM_SH   = 4'd9,
    MEM_SW   = 4'd10,
    MEM_SD   = 4'd11
  } memop_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    DONE = 2'd2
  } lsu_state_t;

  function automatic logic is_load(memop_t op);
    return op inside {MEM_LB, MEM_LH, MEM_LW, MEM_LD, MEM_LBU, MEM_LHU, MEM_LWU};
  endfunction

  function automatic logic is_store(memop_t op);
    return op inside {MEM_SB, MEM_SH, MEM_SW, MEM_SD};
  endfunction

  // log2 of the access width in bytes; non-memory encodings report 0 so they
  // can never be flagged as misaligned.
  function automatic logic [1:0] op_size(memop_t op);
    logic [1:0] sz;
    sz = 2'd0;
    case (op)
      MEM_LH, MEM_LHU, MEM_SH: sz = 2'd1;
      MEM_LW, MEM_LWU, MEM_SW: sz = 2'd2;
      MEM_LD, MEM_SD:          sz = 2'd3;
      default:                 sz = 2'd0;
    endcase
    return sz;
  endfunction

endpackage

// File: rtl/lsu_mem_align.sv
// mem_align: purely combinational byte-lane logic for the LSU.
// Ports:
//   acc_op, acc_off      operation and low address bits of the op being accepted
//   acc_misalign         that op is a misaligned half/word/double access
//   op, off              latched operation and low address bits
//   store_data           latched rs2 value
//   resp_data            raw data-bus response
//   size                 bus access size (0 byte .. 3 double)
//   strobe               byte-enable lanes for stores, 0 for loads
//   wdata                store data moved onto its byte lanes
//   load_data            response data extracted and sign/zero extended
module mem_align
  import lsu_pkg::*;
(
  input  logic [MEMOP_WIDTH-1:0] acc_op,
  input  logic [2:0]             acc_off,
  output logic                   acc_misalign,
  input  logic [MEMOP_WIDTH-1:0] op,
  input  logic [2:0]             off,
  input  logic [63:0]            store_data,
  input  logic [63:0]            resp_data,
  output logic [2:0]             size,
  output logic [7:0]             strobe,
  output logic [63:0]            wdata,
  output logic [63:0]            load_data
);

  memop_t      acc_kind;
  memop_t      kind;
  logic [1:0]  sz;
  logic [5:0]  bit_shift;
  logic [63:0] shifted;
  logic [7:0]  base_strobe;

  assign acc_kind  = memop_t'(acc_op);
  assign kind      = memop_t'(op);
  assign sz        = op_size(kind);
  assign size      = {1'b0, sz};
  assign bit_shift = {off, 3'b000};
  assign shifted   = resp_data >> bit_shift;
  assign wdata     = store_data << bit_shift;

  // Alignment only depends on the low address bits the access width spans.
  always_comb begin
    acc_misalign = 1'b0;
    case (op_size(acc_kind))
      2'd1:    acc_misalign = acc_off[0];
      2'd2:    acc_misalign = |acc_off[1:0];
      2'd3:    acc_misalign = |acc_off;
      default: acc_misalign = 1'b0;
    endcase
  end

  always_comb begin
    base_strobe = 8'h01;
    case (sz)
      2'd1:    base_strobe = 8'h03;
      2'd2:    base_strobe = 8'h0F;
      2'd3:    base_strobe = 8'hFF;
      default: base_strobe = 8'h01;
    endcase
    strobe = is_store(kind) ? (base_strobe << off) : 8'h00;
  end

  always_comb begin
    load_data = 64'd0;
    case (kind)
      MEM_LB:  load_data = {{56{shifted[7]}},  shifted[7:0]};
      MEM_LH:  load_data = {{48{shifted[15]}}, shifted[15:0]};
      MEM_LW:  load_data = {{32{shifted[31]}}, shifted[31:0]};
      MEM_LD:  load_data = shifted;
      MEM_LBU: load_data = {56'd0, shifted[7:0]};
      MEM_LHU: load_data = {48'd0, shifted[15:0]};
      MEM_LWU: load_data = {32'd0, shifted[31:0]};
      default: load_data = 64'd0;
    endcase
  end

endmodule

// File: rtl/lsu.sv
// lsu: load/store unit sitting between the ALU and the data bus.
// Accepts one operation at a time, issues at most one bus request, and
// presents the writeback payload until the consumer takes it.
// Ports:
//   clk, reset                         clock, synchronous active-high reset
//   in_valid/in_ready                  operation handshake from the ALU
//   alu_data, store_data, mem_op       address or result, rs2, operation
//   rd, wen                            destination register and write enable
//   dreq_*                             data-bus request
//   dresp_data_ok, dresp_data          data-bus response
//   out_valid/out_ready                writeback handshake
//   out_data, out_rd, out_wen, misalign writeback payload
module lsu
  import lsu_pkg::*;
(
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [63:0]            alu_data,
  input  logic [63:0]            store_data,
  input  logic [MEMOP_WIDTH-1:0] mem_op,
  input  logic [4:0]             rd,
  input  logic                   wen,
  output logic                   dreq_valid,
  output logic [63:0]            dreq_addr,
  output logic [2:0]             dreq_size,
  output logic [7:0]             dreq_strobe,
  output logic [63:0]            dreq_data,
  input  logic                   dresp_data_ok,
  input  logic [63:0]            dresp_data,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [63:0]            out_data,
  output logic [4:0]             out_rd,
  output logic                   out_wen,
  output logic                   misalign
);

  lsu_state_t state, state_next;

  memop_t      in_op;
  memop_t      op_q;
  logic [63:0] addr_q;
  logic [63:0] store_q;
  logic [63:0] result_q;
  logic [4:0]  rd_q;
  logic        wen_q;
  logic        mis_q;

  logic        accept;
  logic        in_is_mem;
  logic        acc_misalign;
  logic        in_req;
  logic        in_done;
  logic        resp_fire;
  logic [2:0]  size;
  logic [7:0]  strobe;
  logic [63:0] wdata;
  logic [63:0] load_data;

  assign in_op     = memop_t'(mem_op);
  assign in_is_mem = is_load(in_op) | is_store(in_op);
  assign in_ready  = (state == IDLE);
  assign accept    = in_valid & in_ready;
  assign in_req    = (state == REQ);
  assign in_done   = (state == DONE);
  assign resp_fire = in_req & dresp_data_ok;

  mem_align u_mem_align (
    .acc_op       (mem_op),
    .acc_off      (alu_data[2:0]),
    .acc_misalign (acc_misalign),
    .op           (op_q),
    .off          (addr_q[2:0]),
    .store_data   (store_q),
    .resp_data    (dresp_data),
    .size         (size),
    .strobe       (strobe),
    .wdata        (wdata),
    .load_data    (load_data)
  );

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  // Non-memory and misaligned ops skip the bus entirely and report next cycle.
  always_comb begin
    state_next = state;
    case (state)
      IDLE: if (accept) state_next = (!in_is_mem || acc_misalign) ? DONE : REQ;
      REQ:  if (dresp_data_ok) state_next = DONE;
      DONE: if (out_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // The result register carries the ALU value for non-memory ops and is
  // overwritten by the extracted load data when the bus answers; stores and
  // misaligned ops leave it at zero.
  always_ff @(posedge clk) begin
    if (reset) begin
      op_q     <= MEM_NONE;
      addr_q   <= 64'd0;
      store_q  <= 64'd0;
      result_q <= 64'd0;
      rd_q     <= 5'd0;
      wen_q    <= 1'b0;
      mis_q    <= 1'b0;
    end else if (accept) begin
      op_q     <= in_op;
      addr_q   <= alu_data;
      store_q  <= store_data;
      result_q <= in_is_mem ? 64'd0 : alu_data;
      rd_q     <= rd;
      wen_q    <= wen;
      mis_q    <= acc_misalign;
    end else if (resp_fire) begin
      result_q <= is_load(op_q) ? load_data : 64'd0;
    end
  end

  // Outputs are gated by state so that idle and reset leave everything at zero.
  assign dreq_valid  = in_req;
  assign dreq_addr   = in_req ? addr_q : 64'd0;
  assign dreq_size   = in_req ? size   : 3'd0;
  assign dreq_strobe = in_req ? strobe : 8'd0;
  assign dreq_data   = in_req ? wdata  : 64'd0;

  assign out_valid = in_done;
  assign out_data  = in_done ? result_q : 64'd0;
  assign out_rd    = in_done ? rd_q : 5'd0;
  assign out_wen   = in_done & wen_q & ~mis_q & ~is_store(op_q);
  assign misalign  = in_done & mis_q;

endmodule
